// File: rtl/spike_window_counter_if.sv
// Spike counter bus: per-cycle spike population and window control going in,
// the windowed spike total with its sample strobe coming out.
//   master : spike source / consumer side (drives en, spike_in, window_len)
//   slave  : the counter (drives o_spike_cnt, o_cnt_valid, o_win_active)
interface spike_window_counter_if #(
  parameter int NEURONS = 64,
  parameter int LEN_W   = 16
);
  logic               en;
  logic [NEURONS-1:0] spike_in;
  logic [LEN_W-1:0]   window_len;
  logic [31:0]        o_spike_cnt;
  logic               o_cnt_valid;
  logic               o_win_active;

  modport master (
    output en, spike_in, window_len,
    input  o_spike_cnt, o_cnt_valid, o_win_active
  );

  modport slave (
    input  en, spike_in, window_len,
    output o_spike_cnt, o_cnt_valid, o_win_active
  );
endinterface

// File: rtl/spike_window_counter.sv
// Spike window counter: accumulates the popcount of a spike population over a
// programmable window of enabled cycles and publishes the 32-bit total with a
// one-cycle valid strobe (used downstream as the EMG filter sample tick).
// Ports:
//   clk    system clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    slave side of spike_window_counter_if
//          in : en, spike_in[NEURONS], window_len[LEN_W]
//          out: o_spike_cnt[32], o_cnt_valid, o_win_active
module spike_window_counter #(
  parameter int NEURONS = 64,
  parameter int LEN_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  spike_window_counter_if.slave bus
);

  localparam int PC_W = $clog2(NEURONS + 1);

  logic [LEN_W-1:0]   win_cnt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   new_len;
  logic [LEN_W-1:0]   eff_len;
  logic               last;
  logic [NEURONS-1:0] spike_r;
  logic               last_r;
  logic [PC_W-1:0]    pc;
  logic [31:0]        acc;

  // A zero length would never terminate; treat it as a one-cycle window.
  assign new_len = (bus.window_len == '0) ? LEN_W'(1) : bus.window_len;
  // At window start the freshly loaded length governs this very cycle.
  assign eff_len = (win_cnt == '0) ? new_len : len_q;
  assign last    = bus.en && (win_cnt == eff_len - LEN_W'(1));

  assign bus.o_win_active = bus.en || (win_cnt != '0);

  // Window timer: only enabled cycles advance it, so a stalled window stretches.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt <= '0;
      len_q   <= '0;
    end else if (bus.en) begin
      if (win_cnt == '0) len_q <= new_len;
      win_cnt <= last ? '0 : win_cnt + LEN_W'(1);
    end
  end

  // Stage 1: capture. Disabled cycles contribute nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_r <= '0;
      last_r  <= 1'b0;
    end else begin
      spike_r <= bus.en ? bus.spike_in : '0;
      last_r  <= last;
    end
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < NEURONS; i++) pc = pc + PC_W'(spike_r[i]);
  end

  // Stage 2: accumulate, or fold the final cycle in and publish. The
  // accumulator restarts at 0 on publish so back-to-back windows need no gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc             <= '0;
      bus.o_spike_cnt <= '0;
      bus.o_cnt_valid <= 1'b0;
    end else if (last_r) begin
      bus.o_spike_cnt <= acc + 32'(pc);
      acc             <= '0;
      bus.o_cnt_valid <= 1'b1;
    end else begin
      acc             <= acc + 32'(pc);
      bus.o_cnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_window_counter.sv
module tb_spike_window_counter;

  localparam int NEURONS = 64;
  localparam int LEN_W   = 16;

  typedef struct {
    bit               rst;
    bit               en;
    logic [LEN_W-1:0] wl;
    logic [63:0]      spk;
    bit               ca;   // check o_win_active before the edge
    bit               act;
    bit               vld;
    logic [31:0]      cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  vec_t vecs[$];
  int   nvec = 0;
  int   nfail = 0;

  spike_window_counter_if #(.NEURONS(NEURONS), .LEN_W(LEN_W)) bus();

  spike_window_counter #(.NEURONS(NEURONS), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void add(bit rst, bit en, logic [LEN_W-1:0] wl, logic [63:0] spk,
                              bit ca, bit act, bit vld, logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.wl = wl; v.spk = spk;
    v.ca = ca; v.act = act; v.vld = vld; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  initial begin
    logic [63:0] ones;
    logic [63:0] s3;
    bit          seen;
    ones = '1;
    s3   = 64'h7;

    // Reset and idle
    add(1, 0, 4, 0, 0, 0, 0, 0);
    add(1, 0, 4, 0, 0, 0, 0, 0);
    add(0, 0, 4, 0, 1, 0, 0, 0);

    // Full-rate window of 4, all ones: 256 published every 4 cycles
    for (int i = 0; i < 12; i++)
      add(0, 1, 4, ones, 1, 1, (i == 4 || i == 8), (i >= 4) ? 32'd256 : 32'd0);
    add(0, 0, 4, 0, 1, 0, 1, 256);
    add(0, 0, 4, 0, 1, 0, 0, 256);

    // Exact count (3+1) then an empty window that still pulses
    for (int j = 0; j < 8; j++)
      add(0, 1, 4, (j == 0) ? s3 : (j == 2) ? 64'h1 : 64'h0, 1, 1,
          (j == 4), (j >= 4) ? 32'd4 : 32'd256);
    add(0, 0, 4, 0, 1, 0, 1, 0);
    add(0, 0, 4, 0, 1, 0, 0, 0);

    // Enable gating: disabled cycles stretch the window and drop their spikes
    for (int k = 0; k < 2; k++)  add(0, 1, 4, 64'h1, 1, 1, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 4, ones,  1, 1, 0, 0);
    for (int k = 0; k < 2; k++)  add(0, 1, 4, 64'h1, 1, 1, 0, 0);
    add(0, 0, 4, 0, 1, 0, 1, 4);
    add(0, 0, 4, 0, 1, 0, 0, 4);

    // Length change mid-window takes effect at the next window start
    for (int j = 0; j < 10; j++)
      add(0, 1, (j == 0) ? 16'd4 : 16'd2, ones, 1, 1,
          (j == 4 || j == 6 || j == 8),
          (j < 4) ? 32'd4 : (j < 6) ? 32'd256 : 32'd128);
    add(0, 0, 2, 0, 1, 0, 1, 128);
    add(0, 0, 2, 0, 1, 0, 0, 128);

    // Zero length acts as 1: valid every cycle
    for (int j = 0; j < 6; j++)
      add(0, 1, 0, 64'h1, 1, 1, (j >= 1), (j >= 1) ? 32'd1 : 32'd128);
    add(0, 0, 0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1);

    // Reset mid-window discards the partial window
    for (int j = 0; j < 5; j++) add(0, 1, 8, ones, 1, 1, 0, 1);
    add(1, 1, 8, ones, 1, 1, 0, 0);
    // Fresh window of 8 publishes 512; reset coincident with last_r blocks publish
    for (int j = 0; j < 16; j++)
      add(0, 1, 8, ones, 1, 1, (j == 8), (j >= 8) ? 32'd512 : 32'd0);
    add(1, 1, 8, ones, 1, 1, 0, 0);
    add(0, 0, 8, 0, 1, 0, 0, 0);

    foreach (vecs[n]) begin
      reset          = vecs[n].rst;
      bus.en         = vecs[n].en;
      bus.window_len = vecs[n].wl;
      bus.spike_in   = vecs[n].spk;
      #1;
      if (vecs[n].ca) chk("win_active", n, 32'(bus.o_win_active), 32'(vecs[n].act));
      @(posedge clk); #1;
      chk("cnt_valid", n, 32'(bus.o_cnt_valid), 32'(vecs[n].vld));
      chk("spike_cnt", n, bus.o_spike_cnt, vecs[n].cnt);
      nvec++;
    end

    // Alternating enable with window 3: valid exactly 2 cycles after the
    // third enabled cycle, total 3, disabled all-ones cycles ignored.
    seen = 1'b0;
    bus.window_len = 16'd3;
    for (int c = 0; c < 20 && !seen; c++) begin
      bus.en       = (c % 2 == 0);
      bus.spike_in = bus.en ? 64'h1 : ones;
      @(posedge clk); #1;
      if (bus.o_cnt_valid) begin
        seen = 1'b1;
        chk("alt_en_cycle", nvec, 32'(c), 32'd5);
        chk("alt_en_cnt", nvec, bus.o_spike_cnt, 32'd3);
      end
    end
    nvec++;
    if (!seen) begin
      nfail++;
      $display("FAIL alt_en_timeout: got no valid, expected valid within 20 cycles");
    end
    bus.en = 1'b0;
    @(posedge clk); #1;
    chk("alt_en_pulse", nvec, 32'(bus.o_cnt_valid), 32'd0);
    nvec++;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
